async_wr_burst_push: RTL and testbench
======================================

Name: async_wr_burst_push

Overview:
- Write-domain producer that drives the push port of the team's async FIFO. It is the transmitter that generates the write enable which the write-pointer/full logic consumes.
- Accepts an AXI-style burst: an AW-like length handshake followed by W-like data beats with valid/ready.
- Enforces burst framing and absorbs FIFO-full backpressure through a 2-entry skid buffer.
- Pushes beat data plus a last flag into the FIFO. Sits between the crossbar's W-channel slave port and the async FIFO write side.

Parameters:
- DATA_W, 32, beat data width.
- LEN_W, 8, burst length field width (beats = len+1).

Ports:
- wr_clk  input  1  write-domain clock.
- wr_rstn  input  1  asynchronous active-low reset.
- s_awvalid  input  1  burst length valid.
- s_awready  output  1  burst length accepted.
- s_awlen  input  LEN_W  beats minus one.
- s_wvalid  input  1  data beat valid.
- s_wready  output  1  data beat accepted.
- s_wdata  input  DATA_W  beat data.
- s_wlast  input  1  source's last-beat marker (checked only).
- fifo_full  input  1  registered full from FIFO write-pointer logic.
- fifo_wr_en  output  1  push strobe.
- fifo_wr_data  output  DATA_W+1  {last_flag, data}.
- burst_done  output  1  one-cycle pulse when a last_flag beat is pushed.
- len_err  output  1  one-cycle pulse on wlast/length mismatch.

Behaviour:
- Reset and interface:
  - Reset wr_rstn, asynchronous, active-low; clock wr_clk.
  - All flops reset: state=IDLE, beat_cnt=0, len_q=0, both skid entries invalid.
  - Reset values: s_awready=0, s_wready=0, fifo_wr_en=0, fifo_wr_data=0, burst_done=0, len_err=0.
- FSM states: IDLE, DATA.
  - IDLE: s_awready=1, s_wready=0. On s_awvalid&&s_awready: len_q<=s_awlen, beat_cnt<=0, go to DATA.
  - DATA: s_awready=0, s_wready=!skid_full (registered). A beat is accepted on s_wvalid&&s_wready.
  - On each accepted beat: last_flag=(beat_cnt==len_q). If last_flag, go to IDLE; otherwise beat_cnt<=beat_cnt+1.
- Length check:
  - len_err pulses the cycle after an accepted beat where s_wlast != last_flag.
  - The burst still terminates after exactly len_q+1 beats. The pushed last_flag always follows the counted length, never s_wlast.
- Skid buffer:
  - Two entries, main and skid, each {last_flag, data}. Output is taken from main.
  - fifo_wr_en = main_valid && !fifo_full, combinational.
  - On push, skid moves to main; an incoming beat fills whichever entry is free, order preserved.
  - skid_full is registered. s_wready drops the cycle after the second entry fills.
  - No beat is ever lost or duplicated under arbitrary fifo_full toggling.
- fifo_full handling: fifo_full already accounts for the previous push (registered one cycle late), so fifo_wr_en must never assert while fifo_full=1.
- Overlap: IDLE may accept the next AW while prior beats still drain from the skid buffer. Ordering is preserved.
- burst_done: registered pulse, one cycle after a push whose last_flag=1.
- Latency: an accepted beat appears on fifo_wr_en the next cycle if the buffer was empty and fifo_full=0.
- Boundary conditions:
  - s_awlen=0: single-beat burst, return to IDLE after 1 beat.
  - s_awlen=2^LEN_W-1: beat_cnt wraps only via the return to IDLE, never mid-burst.
  - Reset mid-burst discards buffered beats and counters.

Decomposition:
- Shared package: state encoding localparams (IDLE, DATA) and the FIFO entry layout (LAST bit index = DATA_W). Reused by the read-side unpacker.
- One natural sub-module: wr_skid_buf2 (2-entry valid/ready skid buffer, parameterised width).

Test Plan:
- AW len=3, 4 back-to-back beats, wlast on beat 4, fifo_full=0 -> four fifo_wr_en cycles, last_flag only on 4th, burst_done 1 cycle later, len_err=0.
- AW len=0, one beat with wlast=1 -> single push {1,data}, FSM back in IDLE next cycle, s_awready=1.
- AW len=3, fifo_full held 1 from cycle 2 for 10 cycles -> s_wready drops after 2 buffered beats, no fifo_wr_en while full, all 4 beats pushed in order after release.
- AW len=3, wlast on beat 2 -> len_err pulses once; 4 beats pushed, last_flag on beat 4 only.
- Two bursts (len=1, len=2) with AW2 offered while burst 1 drains under fifo_full -> 5 pushes in order, two burst_done pulses.
- wr_rstn asserted mid-burst with 2 buffered beats -> outputs 0 immediately; after release no stale pushes, s_awready=1.

Source files
------------

// File: rtl/async_wr_burst_push_pkg.sv
// rtl/async_wr_burst_push_pkg.sv - shared state encoding and FIFO entry layout for the write burst path
package async_wr_burst_push_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } wr_state_e;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_LEN_W  = 8;

    // FIFO entry is {last_flag, data}; the read-side unpacker uses the same index
    function automatic int unsigned last_bit(input int unsigned data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/wr_skid_buf2.sv
// rtl/wr_skid_buf2.sv - two-entry in-order skid buffer; output always taken from the main entry
module wr_skid_buf2 #(
    parameter int unsigned W = 33
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_in_valid,
    input  logic [W-1:0] i_in_data,
    input  logic         i_out_ready,
    output logic         o_out_valid,
    output logic [W-1:0] o_out_data,
    output logic         o_full
);

    logic         r_main_v;
    logic         r_skid_v;
    logic [W-1:0] r_main_d;
    logic [W-1:0] r_skid_d;
    logic         w_push;

    assign w_push      = r_main_v && i_out_ready;
    assign o_out_valid = r_main_v;
    assign o_out_data  = r_main_d;
    assign o_full      = r_skid_v;

    // Producer must not offer a beat while o_full is set, so skid never overflows
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= '0;
            r_skid_d <= '0;
        end else if (w_push) begin
            if (r_skid_v) begin
                r_main_d <= r_skid_d;
                r_main_v <= 1'b1;
                if (i_in_valid) begin
                    r_skid_d <= i_in_data;
                    r_skid_v <= 1'b1;
                end else begin
                    r_skid_v <= 1'b0;
                end
            end else if (i_in_valid) begin
                r_main_d <= i_in_data;
                r_main_v <= 1'b1;
            end else begin
                r_main_v <= 1'b0;
            end
        end else if (i_in_valid) begin
            if (!r_main_v) begin
                r_main_d <= i_in_data;
                r_main_v <= 1'b1;
            end else begin
                r_skid_d <= i_in_data;
                r_skid_v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_wr_burst_push.sv
// rtl/async_wr_burst_push.sv - write-domain burst framer pushing {last, data} beats into the async FIFO
module async_wr_burst_push
    import async_wr_burst_push_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              wr_clk,
    input  logic              wr_rstn,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [LEN_W-1:0]  s_awlen,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic              s_wlast,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W:0]   fifo_wr_data,
    output logic              burst_done,
    output logic              len_err
);

    localparam int unsigned LAST_IDX = last_bit(DATA_W);

    wr_state_e         r_state;
    wr_state_e         w_state_nxt;
    logic              r_active;
    logic [LEN_W-1:0]  r_len_q;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic              r_burst_done;
    logic              r_len_err;
    logic              w_aw_fire;
    logic              w_beat_acc;
    logic              w_last_flag;
    logic              w_skid_full;
    logic              w_main_valid;
    logic [DATA_W:0]   w_main_data;

    assign w_last_flag = (r_beat_cnt == r_len_q);
    assign w_aw_fire   = s_awvalid && s_awready;
    assign w_beat_acc  = s_wvalid && s_wready;

    // r_active holds s_awready low until the first clock after reset release
    always_comb begin
        w_state_nxt = r_state;
        s_awready   = 1'b0;
        s_wready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_awready = r_active;
                if (s_awvalid && r_active) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                s_wready = !w_skid_full;
                if (s_wvalid && !w_skid_full && w_last_flag) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            r_state      <= ST_IDLE;
            r_active     <= 1'b0;
            r_len_q      <= '0;
            r_beat_cnt   <= '0;
            r_burst_done <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_active     <= 1'b1;
            r_burst_done <= fifo_wr_en && fifo_wr_data[LAST_IDX];
            r_len_err    <= w_beat_acc && (s_wlast != w_last_flag);
            if (w_aw_fire) begin
                r_len_q    <= s_awlen;
                r_beat_cnt <= '0;
            end else if (w_beat_acc && !w_last_flag) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    // Framing comes from the counted length only; s_wlast just feeds len_err
    wr_skid_buf2 #(
        .W (DATA_W + 1)
    ) u_skid (
        .i_clk       (wr_clk),
        .i_rstn      (wr_rstn),
        .i_in_valid  (w_beat_acc),
        .i_in_data   ({w_last_flag, s_wdata}),
        .i_out_ready (!fifo_full),
        .o_out_valid (w_main_valid),
        .o_out_data  (w_main_data),
        .o_full      (w_skid_full)
    );

    assign fifo_wr_en   = w_main_valid && !fifo_full;
    assign fifo_wr_data = w_main_data;
    assign burst_done   = r_burst_done;
    assign len_err      = r_len_err;

endmodule

// File: tb/tb_async_wr_burst_push.sv
// tb/tb_async_wr_burst_push.sv - randomized self-checking bench against a queue-based burst model
module tb_async_wr_burst_push;

    logic        wr_clk = 1'b0;
    logic        wr_rstn;
    logic        s_awvalid;
    logic        s_awready;
    logic [7:0]  s_awlen;
    logic        s_wvalid;
    logic        s_wready;
    logic [31:0] s_wdata;
    logic        s_wlast;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [32:0] fifo_wr_data;
    logic        burst_done;
    logic        len_err;

    always #5 wr_clk = ~wr_clk;

    async_wr_burst_push #(.DATA_W(32), .LEN_W(8)) dut (
        .wr_clk       (wr_clk),
        .wr_rstn      (wr_rstn),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_awlen      (s_awlen),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_wdata      (s_wdata),
        .s_wlast      (s_wlast),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .burst_done   (burst_done),
        .len_err      (len_err)
    );

    typedef struct {
        int len;
        int flip;
    } aw_t;

    aw_t         aw_q[$];
    logic [32:0] exp_q[$];
    bit          in_burst;
    bit          active;
    int          cur_len;
    int          cur_idx;
    int          cur_flip;
    logic        exp_bd;
    logic        exp_le;
    int          full_pct;
    int          wv_pct;
    int          force_full;
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        aw_q.delete();
        exp_q.delete();
        in_burst = 0;
        active   = 0;
        exp_bd   = 0;
        exp_le   = 0;
        cur_len  = 0;
        cur_idx  = 0;
        cur_flip = -1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, s_awready, 0);
        check({tag, "_wready"}, s_wready, 0);
        check({tag, "_wr_en"}, fifo_wr_en, 0);
        check({tag, "_wr_data"}, fifo_wr_data, 0);
        check({tag, "_burst_done"}, burst_done, 0);
        check({tag, "_len_err"}, len_err, 0);
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model
    task automatic tick();
        logic full, awv, wv, wl, e_awr, e_wr, e_wen, last, nbd, nle;
        logic [31:0] wd;
        @(negedge wr_clk);
        full = (force_full > 0) ? 1'b1 : ($urandom_range(99) < full_pct);
        if (force_full > 0) force_full--;
        awv = (aw_q.size() > 0);
        wv  = in_burst && ($urandom_range(99) < wv_pct);
        wd  = $urandom;
        wl  = in_burst && ((cur_idx == cur_len) ^ (cur_idx == cur_flip));
        s_awvalid = awv;
        s_awlen   = awv ? 8'(aw_q[0].len) : 8'($urandom);
        s_wvalid  = wv;
        s_wdata   = wd;
        s_wlast   = wl;
        fifo_full = full;
        #1;
        e_awr = active && !in_burst;
        e_wr  = in_burst && (exp_q.size() < 2);
        e_wen = (exp_q.size() > 0) && !full;
        check("awready", s_awready, e_awr);
        check("wready", s_wready, e_wr);
        check("wr_en", fifo_wr_en, e_wen);
        if (e_wen) check("wr_data", fifo_wr_data, exp_q[0]);
        check("burst_done", burst_done, exp_bd);
        check("len_err", len_err, exp_le);
        nbd = 0;
        nle = 0;
        if (e_wen) begin
            nbd = exp_q[0][32];
            void'(exp_q.pop_front());
        end
        if (awv && e_awr) begin
            in_burst = 1;
            cur_len  = aw_q[0].len;
            cur_flip = aw_q[0].flip;
            cur_idx  = 0;
            void'(aw_q.pop_front());
        end else if (wv && e_wr) begin
            last = (cur_idx == cur_len);
            exp_q.push_back({last, wd});
            nle = (wl != last);
            if (last) in_burst = 0;
            else cur_idx++;
        end
        exp_bd = nbd;
        exp_le = nle;
        active = 1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((aw_q.size() > 0 || in_burst || exp_q.size() > 0 || exp_bd || exp_le) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, (n < budget), 1);
    endtask

    task automatic add_burst(input int len, input int flip);
        aw_t a;
        a.len  = len;
        a.flip = flip;
        aw_q.push_back(a);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        full_pct = 0;
        wv_pct = 100;
        force_full = 0;
        model_reset();
        wr_rstn   = 1'b0;
        s_awvalid = 0;
        s_awlen   = 0;
        s_wvalid  = 0;
        s_wdata   = 0;
        s_wlast   = 0;
        fifo_full = 0;
        #3;
        check_all_zero("reset");
        @(posedge wr_clk);
        #1 wr_rstn = 1'b1;

        add_burst(3, -1);
        drain("b2b_len3", 100);

        add_burst(0, -1);
        drain("single", 100);

        add_burst(3, -1);
        tick();
        tick();
        force_full = 10;
        drain("full_hold", 200);

        add_burst(3, 1);
        drain("early_wlast", 100);

        add_burst(1, -1);
        add_burst(2, -1);
        tick();
        tick();
        force_full = 6;
        drain("overlap", 200);

        add_burst(255, -1);
        full_pct = 30;
        drain("maxlen", 3000);

        for (int g = 0; g < 6; g++) begin
            for (int b = 0; b < 5; b++) begin
                int r, len;
                r = $urandom_range(19);
                len = (r < 3) ? 0 : (r == 3) ? 255 : $urandom_range(15);
                add_burst(len, ($urandom_range(3) == 0) ? $urandom_range(len) : -1);
            end
            full_pct = $urandom_range(70);
            wv_pct = 30 + $urandom_range(70);
            drain("random", 4000);
        end

        full_pct = 0;
        wv_pct = 100;
        add_burst(5, -1);
        force_full = 1000;
        for (int i = 0; i < 20 && exp_q.size() < 2; i++) tick();
        check("rst_prefill", exp_q.size(), 2);
        @(negedge wr_clk);
        #2 wr_rstn = 1'b0;
        #1;
        check_all_zero("midrst");
        force_full = 0;
        model_reset();
        repeat (2) @(posedge wr_clk);
        #1 wr_rstn = 1'b1;
        repeat (4) tick();
        add_burst(2, -1);
        drain("post_rst", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
